dro_array: RTL and testbench

Parametrised, clocked, multi-channel destructive-readout (DRO) storage model with built-in timing-violation checking, the cycle-based successor to the single `basic_dro` cell. Each channel stores one bit on a `set` pulse and emits a one-cycle `out` pulse on `read`. Optionally it runs in non-destructive (NDRO) mode. Per channel it flags set-to-read separation violations and double-set events, and keeps saturating violation counters. It sits in DUT-side behavioural netlists and in benches as the reference model that VCD assertions are checked against.

---
 rtl/dro_array_if.sv | 32 +++
 rtl/dro_array.sv | 116 +++++++++++
 tb/tb_dro_array.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/dro_array_if.sv
//------------------------------------------------------------------------------
// dro_array_if : set/read/clr strobes and readout/violation status of a DRO array
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface dro_array_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
);
  logic [CHANNELS-1:0]       set;
  logic [CHANNELS-1:0]       read;
  logic [CHANNELS-1:0]       clr;
  logic [CHANNELS-1:0]       out;
  logic [CHANNELS-1:0]       state;
  logic [CHANNELS-1:0]       viol_timing;
  logic [CHANNELS-1:0]       viol_dset;
  logic [CHANNELS*CNT_W-1:0] viol_count;
  logic                      any_viol;

  modport master (
    output set, read, clr,
    input  out, state, viol_timing, viol_dset, viol_count, any_viol
  );

  modport slave (
    input  set, read, clr,
    output out, state, viol_timing, viol_dset, viol_count, any_viol
  );
endinterface

`default_nettype wire

// File: rtl/dro_array.sv
//------------------------------------------------------------------------------
// dro_array : multi-channel destructive-readout cells with timing-violation checks
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dro_array #(
  parameter int CHANNELS = 4,
  parameter int MIN_SEP  = 2,
  parameter int CNT_W    = 8,
  parameter int NDRO     = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  dro_array_if.slave  bus
);

  localparam int               AGE_W   = $clog2(MIN_SEP + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MIN_SEP);
  // age is 0 on the edge after the set, so a read at set+MIN_SEP sees MIN_SEP-1
  localparam logic [AGE_W-1:0] AGE_OK  = AGE_W'(MIN_SEP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CHANNELS-1:0] viol_d;
  logic                any_viol_q;
  logic                any_viol_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic             stored_q, stored_d;
    logic [AGE_W-1:0] age_q, age_d;
    logic             out_q, out_d;
    logic             vt_q, vt_d;
    logic             vd_q, vd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      stored_d = stored_q;
      age_d    = (age_q < AGE_MAX) ? age_q + 1'b1 : age_q;
      out_d    = 1'b0;
      vt_d     = 1'b0;
      vd_d     = 1'b0;

      if (bus.read[i]) begin
        if (stored_q) begin
          if (age_q >= AGE_OK) begin
            out_d = 1'b1;
          end else begin
            vt_d = 1'b1;
          end
          if (NDRO == 0) begin
            stored_d = 1'b0;
          end
        end
        if (bus.set[i]) begin
          vt_d = 1'b1;
        end
      end

      if (bus.clr[i]) begin
        stored_d = 1'b0;
      end else if (bus.set[i] && !bus.read[i]) begin
        if (!stored_q) begin
          stored_d = 1'b1;
          age_d    = '0;
        end else begin
          vd_d = 1'b1;
        end
      end

      cnt_d = cnt_q;
      if ((vt_d || vd_d) && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        stored_q <= 1'b0;
        age_q    <= AGE_MAX;
        out_q    <= 1'b0;
        vt_q     <= 1'b0;
        vd_q     <= 1'b0;
        cnt_q    <= '0;
      end else begin
        stored_q <= stored_d;
        age_q    <= age_d;
        out_q    <= out_d;
        vt_q     <= vt_d;
        vd_q     <= vd_d;
        cnt_q    <= cnt_d;
      end
    end

    assign viol_d[i]                        = vt_d | vd_d;
    assign bus.out[i]                       = out_q;
    assign bus.state[i]                     = stored_q;
    assign bus.viol_timing[i]               = vt_q;
    assign bus.viol_dset[i]                 = vd_q;
    assign bus.viol_count[i*CNT_W +: CNT_W] = cnt_q;
  end

  assign any_viol_d = any_viol_q | (|viol_d);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      any_viol_q <= 1'b0;
    end else begin
      any_viol_q <= any_viol_d;
    end
  end

  assign bus.any_viol = any_viol_q;

endmodule

`default_nettype wire

// File: tb/tb_dro_array.sv
//------------------------------------------------------------------------------
// tb_dro_array : directed bench for dro_array, DRO (CNT_W=2) and NDRO instances
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dro_array;

  localparam int MIN_SEP = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] d_set, d_read, d_clr;
  bit         chk_en = 1'b0;
  int         total = 0;
  int         bad   = 0;
  int         now   = 0;

  always #5 clk = ~clk;

  dro_array_if #(.CHANNELS(4), .CNT_W(2)) ifa ();
  dro_array_if #(.CHANNELS(4), .CNT_W(8)) ifb ();

  assign ifa.set  = d_set;
  assign ifa.read = d_read;
  assign ifa.clr  = d_clr;
  assign ifb.set  = d_set;
  assign ifb.read = d_read;
  assign ifb.clr  = d_clr;

  dro_array #(.CHANNELS(4), .MIN_SEP(MIN_SEP), .CNT_W(2), .NDRO(0)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  dro_array #(.CHANNELS(4), .MIN_SEP(MIN_SEP), .CNT_W(8), .NDRO(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  // Model: each cell remembers the edge index of its accepted set
  typedef struct {
    bit st;
    int sc;
    int cnt;
    bit o;
    bit vt;
    bit vd;
  } chs_t;

  chs_t m [2][4];
  bit   m_any [2];

  function automatic chs_t step_ch(chs_t c, bit s, bit r, bit cl, bit ndro, int cmax, int t);
    chs_t n = c;
    n.o  = 1'b0;
    n.vt = 1'b0;
    n.vd = 1'b0;
    if (r) begin
      if (c.st) begin
        if (t - c.sc >= MIN_SEP) n.o = 1'b1;
        else n.vt = 1'b1;
        if (!ndro) n.st = 1'b0;
      end
      if (s) n.vt = 1'b1;
    end
    if (cl) n.st = 1'b0;
    else if (s && !r) begin
      if (!c.st) begin
        n.st = 1'b1;
        n.sc = t;
      end else begin
        n.vd = 1'b1;
      end
    end
    if ((n.vt || n.vd) && n.cnt < cmax) n.cnt = n.cnt + 1;
    return n;
  endfunction

  function automatic chs_t nxt(int k, int ch);
    chs_t z = '{0, -1000, 0, 0, 0, 0};
    if (!rst_n) return z;
    return step_ch(m[k][ch], d_set[ch], d_read[ch], d_clr[ch], (k == 1), (k == 0) ? 3 : 255, now);
  endfunction

  function automatic bit any_next(int k);
    bit v = m_any[k];
    chs_t n;
    if (!rst_n) return 1'b0;
    for (int ch = 0; ch < 4; ch++) begin
      n = nxt(k, ch);
      v = v | n.vt | n.vd;
    end
    return v;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int ch = 0; ch < 4; ch++) m[k][ch] <= nxt(k, ch);
      m_any[k] <= any_next(k);
    end
    now <= now + 1;
  end

  function automatic logic [3:0] ev(int k, int f);
    logic [3:0] v = '0;
    for (int ch = 0; ch < 4; ch++) begin
      case (f)
        0:       v[ch] = m[k][ch].o;
        1:       v[ch] = m[k][ch].vt;
        2:       v[ch] = m[k][ch].vd;
        default: v[ch] = m[k][ch].st;
      endcase
    end
    return v;
  endfunction

  function automatic logic [31:0] ec(int k, int w);
    logic [31:0] v = '0;
    for (int ch = 0; ch < 4; ch++) v = v | (32'(m[k][ch].cnt) << (ch * w));
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a.out",   32'(ifa.out),         32'(ev(0, 0)));
      chk("a.vt",    32'(ifa.viol_timing), 32'(ev(0, 1)));
      chk("a.vd",    32'(ifa.viol_dset),   32'(ev(0, 2)));
      chk("a.state", 32'(ifa.state),       32'(ev(0, 3)));
      chk("a.cnt",   32'(ifa.viol_count),  ec(0, 2));
      chk("a.any",   32'(ifa.any_viol),    32'(m_any[0]));
      chk("b.out",   32'(ifb.out),         32'(ev(1, 0)));
      chk("b.vt",    32'(ifb.viol_timing), 32'(ev(1, 1)));
      chk("b.vd",    32'(ifb.viol_dset),   32'(ev(1, 2)));
      chk("b.state", 32'(ifb.state),       32'(ev(1, 3)));
      chk("b.cnt",   ifb.viol_count,       ec(1, 8));
      chk("b.any",   32'(ifb.any_viol),    32'(m_any[1]));
    end
  end

  task automatic cyc(input logic rn, input logic [3:0] s, input logic [3:0] r, input logic [3:0] c);
    rst_n  = rn;
    d_set  = s;
    d_read = r;
    d_clr  = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(1'b0, 4'b0000, 4'b0000, 4'b0000);
    cyc(1'b0, 4'b0000, 4'b0000, 4'b0000);
    chk_en = 1'b1;
    chk("rst_state", 32'(ifa.state), 32'h0);
    chk("rst_cnt",   32'(ifa.viol_count), 32'h0);
    chk("rst_any",   32'(ifa.any_viol), 32'h0);

    // ch0 set two edges before its read, ch2 set only one edge before
    cyc(1'b1, 4'b0001, 4'b0000, 4'b0000);
    cyc(1'b1, 4'b0100, 4'b0000, 4'b0000);
    cyc(1'b1, 4'b0000, 4'b0101, 4'b0000);
    chk("mc_out",     32'(ifa.out), 32'h1);
    chk("mc_vt",      32'(ifa.viol_timing), 32'h4);
    chk("mc_cnt",     32'(ifa.viol_count), 32'h10);
    chk("mc_any",     32'(ifa.any_viol), 32'h1);
    chk("mc_state_a", 32'(ifa.state), 32'h0);
    chk("mc_state_b", 32'(ifb.state), 32'h5);
    cyc(1'b1, 4'b0000, 4'b0000, 4'b0000);
    chk("pulse_len", 32'(ifa.out), 32'h0);

    // double set on ch1 at +0 and +3, read at +4
    cyc(1'b1, 4'b0010, 4'b0000, 4'b0000);
    cyc(1'b1, 4'b0000, 4'b0000, 4'b0000);
    cyc(1'b1, 4'b0000, 4'b0000, 4'b0000);
    cyc(1'b1, 4'b0010, 4'b0000, 4'b0000);
    chk("dset",       32'(ifa.viol_dset), 32'h2);
    chk("dset_state", 32'(ifa.state[1]), 32'h1);
    cyc(1'b1, 4'b0000, 4'b0010, 4'b0000);
    chk("dset_read",  32'(ifa.out), 32'h2);

    // set and read together on empty ch3
    cyc(1'b1, 4'b1000, 4'b1000, 4'b0000);
    chk("sr_out",   32'(ifa.out), 32'h0);
    chk("sr_vt",    32'(ifa.viol_timing), 32'h8);
    chk("sr_state", 32'(ifa.state[3]), 32'h0);

    // back-to-back reads of ch0: NDRO keeps firing, DRO cell is empty
    repeat (3) begin
      cyc(1'b1, 4'b0000, 4'b0001, 4'b0000);
      chk("ndro_out",   32'(ifb.out), 32'h1);
      chk("ndro_state", 32'(ifb.state[0]), 32'h1);
      chk("dro_empty",  32'(ifa.out), 32'h0);
    end
    cyc(1'b1, 4'b0000, 4'b0000, 4'b0001);
    chk("ndro_clr",     32'(ifb.state[0]), 32'h0);
    chk("ndro_clr_out", 32'(ifb.out), 32'h0);

    // five more violations on ch3
    repeat (5) cyc(1'b1, 4'b1000, 4'b1000, 4'b0000);
    chk("sat_a", 32'(ifa.viol_count[7:6]), 32'h3);
    chk("cnt_b", 32'(ifb.viol_count[31:24]), 32'h6);

    cyc(1'b1, 4'b0001, 4'b0000, 4'b0001);
    chk("clr_set_state", 32'(ifa.state[0]), 32'h0);
    chk("clr_set_flag",  32'(ifa.viol_dset), 32'h0);

    cyc(1'b0, 4'b1111, 4'b0000, 4'b0000);
    chk("rst_mid_state", 32'(ifa.state), 32'h0);
    chk("rst_mid_cnt",   32'(ifa.viol_count), 32'h0);
    chk("rst_mid_any",   32'(ifa.any_viol), 32'h0);
    chk("rst_mid_b",     32'(ifb.state), 32'h0);

    cyc(1'b1, 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
